// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIBBLE = 4;

  function automatic int slices(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice; every carry comes from generate/propagate terms.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer: one shared 4-bit CLA, one nibble per clock, LSB first,
// with the slice carry registered between passes.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICES = slices(WIDTH);
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t          state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic            carry_r;
  logic [IW-1:0]   idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_s;
  logic       nib_c;

  assign nib_a = a_r[NIBBLE*idx +: NIBBLE];
  assign nib_b = b_r[NIBBLE*idx +: NIBBLE];

  cla4 u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_r),
    .s    (nib_s),
    .cout (nib_c)
  );

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the inversion and the +1 are folded in here.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[NIBBLE*idx +: NIBBLE] <= nib_s;
          carry_r <= nib_c;
          idx     <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= nib_c;
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_s[3] != a_r[WIDTH-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
